// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-core tile sequencer.
//   sa_seq_state_t : tile sequencer states
//   sa_drain_len   : bubble cycles needed to flush the skewed PE array
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    OUT
  } sa_seq_state_t;

  // The last operand enters the far corner PE ROWS+COLS-2 cycles after the
  // first one, plus any extra per-PE pipeline stages.
  function automatic int sa_drain_len(input int rows, input int cols, input int pe_lat);
    return rows + cols - 2 + pe_lat;
  endfunction

endpackage

// File: rtl/sa_core_seq.sv
// Tile sequencer for the systolic core.
// Runs K reduction steps per tile, gated by the per-lane input FIFO empty
// flags, then injects bubble cycles to drain the skewed array, then hands
// the results to the column output controllers under a ready handshake.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   start/k_len/acc_mode tile request (one request can be queued)
//   abort                synchronous abort back to IDLE
//   a_empty/w_empty      per-lane input FIFO empty flags
//   out_ready            output controllers can accept a result set
//   fire/pop/bubble      PE array advance, FIFO pop, zero injection
//   clear_acc            clear PE accumulators on this fire
//   out_capture          output controllers latch PE results
//   busy/done/err        status: not idle, tile complete pulse, reject pulse
//   tile_cnt/stall_cnt   completed tiles (wraps), starved RUN cycles (saturates)
module sa_core_seq
  import sa_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int KW     = 16,
  parameter int PE_LAT = 1,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          acc_mode,
  input  logic          abort,
  input  logic [ROWS-1:0] a_empty,
  input  logic [COLS-1:0] w_empty,
  input  logic          out_ready,
  output logic          fire,
  output logic          pop,
  output logic          bubble,
  output logic          clear_acc,
  output logic          out_capture,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] tile_cnt,
  output logic [CW-1:0] stall_cnt
);

  localparam int D  = sa_drain_len(ROWS, COLS, PE_LAT);
  localparam int DW = (D < 2) ? 1 : $clog2(D + 1);

  sa_seq_state_t state;
  logic [KW-1:0] k_len_q;
  logic [KW-1:0] k_cnt;
  logic          acc_q;
  logic          pending;
  logic [KW-1:0] pend_k;
  logic          pend_acc;
  logic [DW-1:0] d_cnt;

  logic avail;
  logic k_zero;
  logic start_ok;

  assign avail    = ~|a_empty & ~|w_empty;
  assign k_zero   = (k_len == '0);
  assign start_ok = start & ~k_zero & ~pending;
  assign busy     = (state != IDLE);

  always_comb begin
    fire        = 1'b0;
    pop         = 1'b0;
    bubble      = 1'b0;
    clear_acc   = 1'b0;
    out_capture = 1'b0;
    case (state)
      RUN: begin
        fire      = avail;
        pop       = avail;
        clear_acc = avail & (k_cnt == '0) & ~acc_q;
      end
      DRAIN: begin
        fire   = 1'b1;
        bubble = 1'b1;
      end
      OUT:     out_capture = out_ready & ~abort;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      k_len_q   <= '0;
      k_cnt     <= '0;
      acc_q     <= 1'b0;
      pending   <= 1'b0;
      pend_k    <= '0;
      pend_acc  <= 1'b0;
      d_cnt     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      tile_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        pending <= 1'b0;
      end else begin
        // Request intake
        case (state)
          IDLE: begin
            if (start) begin
              if (k_zero) begin
                err <= 1'b1;
              end else begin
                k_len_q <= k_len;
                acc_q   <= acc_mode;
                k_cnt   <= '0;
                state   <= RUN;
              end
            end
          end
          default: begin
            if (start) begin
              if (pending || k_zero) begin
                err <= 1'b1;
              end else if (!out_capture) begin
                pending  <= 1'b1;
                pend_k   <= k_len;
                pend_acc <= acc_mode;
              end
            end
          end
        endcase

        // Tile progress
        case (state)
          RUN: begin
            if (avail) begin
              k_cnt <= k_cnt + KW'(1);
              if (k_cnt == k_len_q - KW'(1)) begin
                state <= (D == 0) ? OUT : DRAIN;
                d_cnt <= DW'(D);
              end
            end else if (stall_cnt != '1) begin
              stall_cnt <= stall_cnt + CW'(1);
            end
          end
          DRAIN: begin
            d_cnt <= d_cnt - DW'(1);
            if (d_cnt == DW'(1)) state <= OUT;
          end
          OUT: begin
            if (out_capture) begin
              done     <= 1'b1;
              tile_cnt <= tile_cnt + CW'(1);
              k_cnt    <= '0;
              // A start arriving on the capture cycle with nothing queued
              // is taken directly rather than parked in pending.
              if (pending) begin
                k_len_q <= pend_k;
                acc_q   <= pend_acc;
                pending <= 1'b0;
                state   <= RUN;
              end else if (start_ok) begin
                k_len_q <= k_len;
                acc_q   <= acc_mode;
                state   <= RUN;
              end else begin
                state <= IDLE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sa_core_seq.sv
// Directed, table-driven bench for sa_core_seq with ROWS=COLS=4, PE_LAT=1
// (drain length 7). Each table row is one clock cycle: inputs are driven
// just after the falling edge and the outputs checked shortly before the
// next rising edge.
module tb_sa_core_seq;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int KW   = 16;
  localparam int CW   = 16;

  // Expected-output bit positions in {fire,pop,bubble,clear_acc,out_capture,busy,done,err}
  localparam logic [7:0] FI = 8'b1000_0000;
  localparam logic [7:0] PO = 8'b0100_0000;
  localparam logic [7:0] BU = 8'b0010_0000;
  localparam logic [7:0] CL = 8'b0001_0000;
  localparam logic [7:0] CA = 8'b0000_1000;
  localparam logic [7:0] BZ = 8'b0000_0100;
  localparam logic [7:0] DN = 8'b0000_0010;
  localparam logic [7:0] ER = 8'b0000_0001;

  logic            clk = 1'b0;
  logic            rstn;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            acc_mode;
  logic            abort;
  logic [ROWS-1:0] a_empty;
  logic [COLS-1:0] w_empty;
  logic            out_ready;
  logic            fire, pop, bubble, clear_acc, out_capture, busy, done, err;
  logic [CW-1:0]   tile_cnt, stall_cnt;
  logic [7:0]      act;

  assign act = {fire, pop, bubble, clear_acc, out_capture, busy, done, err};

  always #5 clk = ~clk;

  sa_core_seq #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .KW    (KW),
    .PE_LAT(1),
    .CW    (CW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .k_len      (k_len),
    .acc_mode   (acc_mode),
    .abort      (abort),
    .a_empty    (a_empty),
    .w_empty    (w_empty),
    .out_ready  (out_ready),
    .fire       (fire),
    .pop        (pop),
    .bubble     (bubble),
    .clear_acc  (clear_acc),
    .out_capture(out_capture),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .tile_cnt   (tile_cnt),
    .stall_cnt  (stall_cnt)
  );

  typedef struct {
    logic            st;
    logic [KW-1:0]   k;
    logic            acc;
    logic            ab;
    logic [ROWS-1:0] ae;
    logic [COLS-1:0] we;
    logic            rdy;
    logic [7:0]      exp;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   row_id   = 0;

  function automatic vec_t v(input logic st, input int k, input logic acc, input logic ab,
                             input logic [ROWS-1:0] ae, input logic [COLS-1:0] we,
                             input logic rdy, input logic [7:0] exp);
    vec_t r;
    r.st = st; r.k = KW'(k); r.acc = acc; r.ab = ab;
    r.ae = ae; r.we = we; r.rdy = rdy; r.exp = exp;
    return r;
  endfunction

  // Idle-input row with the given expectation
  function automatic vec_t q0(input logic [7:0] exp);
    return v(1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b1, exp);
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h (t=%0t)", nm, idx, a, e, $time);
    end
  endtask

  task automatic run_table(input string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      start     = tbl[i].st;
      k_len     = tbl[i].k;
      acc_mode  = tbl[i].acc;
      abort     = tbl[i].ab;
      a_empty   = tbl[i].ae;
      w_empty   = tbl[i].we;
      out_ready = tbl[i].rdy;
      #3;
      check(nm, i, 32'(act), 32'(tbl[i].exp));
    end
    tbl.delete();
    row_id++;
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; k_len = '0; acc_mode = 1'b0; abort = 1'b0;
    a_empty = '0; w_empty = '0; out_ready = 1'b1;
    #2;
    check("reset_out", 0, 32'(act), 32'd0);
    check("reset_tile", 0, 32'(tile_cnt), 32'd0);
    check("reset_stall", 0, 32'(stall_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Basic tile, k_len=3
    tbl.push_back(v(1, 3, 0, 0, '0, '0, 1, 8'h00));
    tbl.push_back(q0(FI | PO | CL | BZ));
    repeat (2) tbl.push_back(q0(FI | PO | BZ));
    repeat (7) tbl.push_back(q0(FI | BU | BZ));
    tbl.push_back(q0(CA | BZ));
    tbl.push_back(q0(DN));
    run_table("basic");
    check("basic_tile", 0, 32'(tile_cnt), 32'd1);

    // Stall: a_empty[2] for 4 RUN cycles; drain ignores empty flags
    tbl.push_back(v(1, 2, 0, 0, '0, '0, 1, 8'h00));
    repeat (4) tbl.push_back(v(0, 0, 0, 0, 4'b0100, '0, 1, BZ));
    tbl.push_back(q0(FI | PO | CL | BZ));
    tbl.push_back(q0(FI | PO | BZ));
    repeat (7) tbl.push_back(v(0, 0, 0, 0, '0, 4'hF, 1, FI | BU | BZ));
    tbl.push_back(q0(CA | BZ));
    tbl.push_back(q0(DN));
    run_table("stall");
    check("stall_cnt", 0, 32'(stall_cnt), 32'd4);
    check("stall_tile", 0, 32'(tile_cnt), 32'd2);

    // Rejection of k_len=0 from IDLE
    tbl.push_back(v(1, 0, 0, 0, '0, '0, 1, 8'h00));
    tbl.push_back(q0(ER));
    tbl.push_back(q0(8'h00));
    run_table("reject");

    // Backpressure in OUT, plus a zero-length start during DRAIN
    tbl.push_back(v(1, 1, 0, 0, '0, '0, 1, 8'h00));
    tbl.push_back(q0(FI | PO | CL | BZ));
    tbl.push_back(q0(FI | BU | BZ));
    tbl.push_back(v(1, 0, 0, 0, '0, '0, 1, FI | BU | BZ));
    tbl.push_back(q0(FI | BU | BZ | ER));
    repeat (4) tbl.push_back(q0(FI | BU | BZ));
    repeat (5) tbl.push_back(v(0, 0, 0, 0, '0, '0, 0, BZ));
    tbl.push_back(q0(CA | BZ));
    tbl.push_back(q0(DN));
    tbl.push_back(q0(8'h00));
    run_table("backpr");
    check("backpr_tile", 0, 32'(tile_cnt), 32'd3);

    // Queued start during DRAIN (k=2, acc=1); second start while pending rejected
    tbl.push_back(v(1, 1, 0, 0, '0, '0, 1, 8'h00));
    tbl.push_back(q0(FI | PO | CL | BZ));
    tbl.push_back(v(1, 2, 1, 0, '0, '0, 1, FI | BU | BZ));
    tbl.push_back(v(1, 5, 0, 0, '0, '0, 1, FI | BU | BZ));
    tbl.push_back(q0(FI | BU | BZ | ER));
    repeat (4) tbl.push_back(q0(FI | BU | BZ));
    tbl.push_back(q0(CA | BZ));
    tbl.push_back(q0(FI | PO | BZ | DN));
    tbl.push_back(q0(FI | PO | BZ));
    repeat (7) tbl.push_back(q0(FI | BU | BZ));
    tbl.push_back(q0(CA | BZ));
    tbl.push_back(q0(DN));
    tbl.push_back(q0(8'h00));
    run_table("queued");
    check("queued_tile", 0, 32'(tile_cnt), 32'd5);

    // Abort in DRAIN with a simultaneous start: nothing queued, no done
    tbl.push_back(v(1, 1, 0, 0, '0, '0, 1, 8'h00));
    tbl.push_back(q0(FI | PO | CL | BZ));
    tbl.push_back(q0(FI | BU | BZ));
    tbl.push_back(v(1, 2, 0, 1, '0, '0, 1, FI | BU | BZ));
    repeat (3) tbl.push_back(q0(8'h00));
    run_table("abort");
    check("abort_tile", 0, 32'(tile_cnt), 32'd5);
    check("abort_stall", 0, 32'(stall_cnt), 32'd4);

    // Accumulate mode from IDLE: no clear on first fire; abort mid-RUN
    tbl.push_back(v(1, 2, 1, 0, '0, '0, 1, 8'h00));
    tbl.push_back(q0(FI | PO | BZ));
    tbl.push_back(v(0, 0, 0, 1, '0, '0, 1, FI | PO | BZ));
    tbl.push_back(q0(8'h00));
    run_table("accmode");

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    start = 1'b1; k_len = KW'(4); acc_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #3;
    check("pre_rst_run", 0, 32'(act), 32'(FI | PO | CL | BZ));
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_out", 0, 32'(act), 32'd0);
    check("rst_tile", 0, 32'(tile_cnt), 32'd0);
    check("rst_stall", 0, 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #3;
    check("post_rst", 0, 32'(act), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
